snake_mover: RTL and testbench
==============================

# snake_mover

Game-state engine for the snake: on each game-tick pulse it advances the head one grid cell in the requested direction, shifts the body, grows on apple contact, and detects wall and self collisions. Its head, apple-independent body and length outputs are the live game-state buses that the per-frame latch samples at frame start for rendering. It runs entirely in the pixel clock domain.

## Interface

- MAX_LEN, 33: body slots on the bus; segment 0 is the head.
- CELL, 16: grid cell size in pixels; all coordinates are multiples of CELL.
- GRID_W, 40: playfield width in cells (x cell 0..GRID_W-1).
- GRID_H, 30: playfield height in cells (y cell 0..GRID_H-1).
- START_X, 20: initial head x cell; must be >= START_LEN-1.
- START_Y, 15: initial head y cell.
- START_LEN, 3: initial length, 1..MAX_LEN.

- clk_pix  in  1  pixel clock, the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- step  in  1  single-cycle game-tick pulse.
- dir  in  2  requested heading: 0 up, 1 right, 2 down, 3 left.
- restart  in  1  synchronous return to the initial state.
- apple_x  in  10  apple pixel x.
- apple_y  in  9  apple pixel y.
- head_x  out  10  head pixel x.
- head_y  out  9  head pixel y.
- snake_len  out  8  current length including the head.
- body_bus_x  out  MAX_LEN*10  segment i x at [i*10 +: 10].
- body_bus_y  out  MAX_LEN*9  segment i y at [i*9 +: 9].
- apple_eaten  out  1  one-cycle pulse when the head lands on the apple.
- game_over  out  1  sticky collision flag.
- busy  out  1  high while a step is being processed.

## Operation

- Reset and restart set: segment i = ((START_X-i)*CELL, START_Y*CELL) for i < START_LEN, and every slot i >= START_LEN = segment START_LEN-1. Also head = segment 0, snake_len = START_LEN, heading = right, game_over = 0, apple_eaten = 0, busy = 0, state IDLE.
- restart has priority over all other activity in every state.
- States: IDLE, MOVE, CHECK, DEAD.
- IDLE: on step, latch the heading and go to MOVE. dir is accepted only if it is not the exact opposite of the current heading; otherwise the current heading is kept.
- MOVE: the next head is the head ± CELL on one axis.
  - If the next head leaves the playfield (x cell < 0 or >= GRID_W, y cell < 0 or >= GRID_H), nothing moves and the state goes to DEAD.
  - Otherwise every slot shifts (seg[i] <= seg[i-1] for i = 1..MAX_LEN-1) and seg[0] and the head take the next-head value.
  - If the next head equals (apple_x, apple_y), pulse apple_eaten. If snake_len < MAX_LEN, also increment snake_len; at MAX_LEN the length saturates and apple_eaten still pulses.
  - Next state is CHECK, or IDLE if the new snake_len == 1.
- CHECK: compare the head against seg[i] for i = 1..snake_len-1, one index per cycle. On a match go to DEAD. After index snake_len-1 with no match, go to IDLE.
- DEAD: game_over = 1. Outputs are frozen, step is ignored, and only restart or reset leaves this state.
- Growth keeps the old tail, because the shifted slot snake_len-1 holds the previous tail. Moving into the cell the tail just vacated is legal.
- step is ignored when the state is not IDLE; no queuing.
- Wall detection uses signed/extended cell arithmetic, so x cell 0 moving left is caught and does not wrap.

## Timing

- step is high in cycle T (IDLE). MOVE runs in cycle T+1.
- head, body buses and snake_len update at the end of T+1. apple_eaten is high during cycle T+2 only.
- CHECK takes snake_len-1 cycles, T+2 .. T+snake_len.
- busy is high from T+1 until the cycle the state returns to IDLE, so a non-colliding step holds busy for snake_len cycles. busy is 0 in DEAD.
- game_over rises in the cycle after the collision is detected: T+2 for a wall, the cycle after the matching index for self collision.
- Asynchronous reset in any state, including mid-CHECK, immediately forces all reset values. restart does the same at the next clock edge.

## Test plan

- Reset with defaults → head (320,240), seg1 (304,240), seg2 (288,240), slots 3..32 = (288,240), len 3, busy 0, game_over 0.
- One step with dir=1 → head (336,240), seg1 (320,240), seg2 (304,240), len 3, busy high for exactly 3 cycles.
- From reset, dir=3 (reverse) then step → move right to (336,240); dir=0 then step → head (336,224).
- Apple at (336,240), step right → apple_eaten pulses once at T+2, len 4, seg3 (288,240).
- Head at x cell 39 heading right, step → no movement, game_over=1 at T+2; further steps ignored; restart returns the reset state.
- Grow to length 5, then steer up, left, down → game_over after the matching CHECK index. At MAX_LEN, eating holds len at 33 while apple_eaten still pulses.

Source files
------------

// File: rtl/snake_mover.sv
// Snake game-state engine: advances the head one cell per game tick, shifts the body,
// grows on apple contact and detects wall and self collisions, all in the pixel clock domain.
module snake_mover #(
    parameter int MAX_LEN   = 33,
    parameter int CELL      = 16,
    parameter int GRID_W    = 40,
    parameter int GRID_H    = 30,
    parameter int START_X   = 20,
    parameter int START_Y   = 15,
    parameter int START_LEN = 3
) (
    input  logic                  clk_pix,
    input  logic                  rst_n,
    input  logic                  step,
    input  logic [1:0]            dir,
    input  logic                  restart,
    input  logic [9:0]            apple_x,
    input  logic [8:0]            apple_y,
    output logic [9:0]            head_x,
    output logic [8:0]            head_y,
    output logic [7:0]            snake_len,
    output logic [MAX_LEN*10-1:0] body_bus_x,
    output logic [MAX_LEN*9-1:0]  body_bus_y,
    output logic                  apple_eaten,
    output logic                  game_over,
    output logic                  busy
);

    localparam int IW = $clog2(MAX_LEN);
    localparam logic signed [11:0] CELL_S = 12'(CELL);
    localparam logic signed [11:0] X_LIM  = 12'(GRID_W * CELL);
    localparam logic signed [11:0] Y_LIM  = 12'(GRID_H * CELL);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MOVE  = 2'd1,
        S_CHECK = 2'd2,
        S_DEAD  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [9:0]         r_seg_x [MAX_LEN];
    logic [8:0]         r_seg_y [MAX_LEN];
    logic [1:0]         r_heading;
    logic [7:0]         r_len;
    logic [IW-1:0]      r_idx;
    logic               r_eaten;
    logic               r_game_over;
    logic               r_busy;

    logic signed [11:0] w_nx;
    logic signed [11:0] w_ny;
    logic               w_wall;
    logic               w_hit_apple;
    logic [7:0]         w_new_len;
    logic               w_self_hit;
    logic               w_last_idx;

    // Slots past the initial tail all stack on the initial tail cell.
    function automatic logic [9:0] init_x(input int i);
        if (i < START_LEN) begin
            init_x = 10'((START_X - i) * CELL);
        end else begin
            init_x = 10'((START_X - START_LEN + 1) * CELL);
        end
    endfunction

    // Candidate head position, extended and signed so a step off the left/top edge goes negative.
    always_comb begin
        w_nx = $signed({2'b00, r_seg_x[0]});
        w_ny = $signed({3'b000, r_seg_y[0]});
        case (r_heading)
            2'd0:    w_ny = w_ny - CELL_S;
            2'd1:    w_nx = w_nx + CELL_S;
            2'd2:    w_ny = w_ny + CELL_S;
            2'd3:    w_nx = w_nx - CELL_S;
            default: w_nx = w_nx;
        endcase
    end

    assign w_wall      = (w_nx < 12'sd0) || (w_nx >= X_LIM) || (w_ny < 12'sd0) || (w_ny >= Y_LIM);
    assign w_hit_apple = (w_nx[9:0] == apple_x) && (w_ny[8:0] == apple_y);
    assign w_new_len   = (w_hit_apple && (r_len < 8'(MAX_LEN))) ? (r_len + 8'd1) : r_len;
    assign w_self_hit  = (r_seg_x[0] == r_seg_x[r_idx]) && (r_seg_y[0] == r_seg_y[r_idx]);
    assign w_last_idx  = (8'(r_idx) == (r_len - 8'd1));

    // State register.
    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; restart overrides every state.
    always_comb begin
        w_next_state = r_state;
        if (restart) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (step) begin
                        w_next_state = S_MOVE;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end
                S_MOVE: begin
                    if (w_wall) begin
                        w_next_state = S_DEAD;
                    end else if (w_new_len == 8'd1) begin
                        w_next_state = S_IDLE;
                    end else begin
                        w_next_state = S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_self_hit) begin
                        w_next_state = S_DEAD;
                    end else if (w_last_idx) begin
                        w_next_state = S_IDLE;
                    end else begin
                        w_next_state = S_CHECK;
                    end
                end
                S_DEAD:  w_next_state = S_DEAD;
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    // Body, heading, length and registered status flags.
    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                r_seg_x[i] <= init_x(i);
                r_seg_y[i] <= 9'(START_Y * CELL);
            end
            r_heading   <= 2'd1;
            r_len       <= 8'(START_LEN);
            r_idx       <= IW'(1);
            r_eaten     <= 1'b0;
            r_game_over <= 1'b0;
            r_busy      <= 1'b0;
        end else if (restart) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                r_seg_x[i] <= init_x(i);
                r_seg_y[i] <= 9'(START_Y * CELL);
            end
            r_heading   <= 2'd1;
            r_len       <= 8'(START_LEN);
            r_idx       <= IW'(1);
            r_eaten     <= 1'b0;
            r_game_over <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_eaten     <= 1'b0;
            r_busy      <= (w_next_state == S_MOVE) || (w_next_state == S_CHECK);
            r_game_over <= (w_next_state == S_DEAD);
            case (r_state)
                S_IDLE: begin
                    if (step && (dir != (r_heading ^ 2'd2))) begin
                        r_heading <= dir;
                    end
                end
                S_MOVE: begin
                    r_idx <= IW'(1);
                    if (!w_wall) begin
                        for (int i = 1; i < MAX_LEN; i++) begin
                            r_seg_x[i] <= r_seg_x[i-1];
                            r_seg_y[i] <= r_seg_y[i-1];
                        end
                        r_seg_x[0] <= w_nx[9:0];
                        r_seg_y[0] <= w_ny[8:0];
                        r_len      <= w_new_len;
                        r_eaten    <= w_hit_apple;
                    end
                end
                S_CHECK: r_idx <= r_idx + IW'(1);
                default: r_idx <= r_idx;
            endcase
        end
    end

    for (genvar g = 0; g < MAX_LEN; g++) begin : g_bus
        assign body_bus_x[g*10 +: 10] = r_seg_x[g];
        assign body_bus_y[g*9 +: 9]   = r_seg_y[g];
    end

    assign head_x      = r_seg_x[0];
    assign head_y      = r_seg_y[0];
    assign snake_len   = r_len;
    assign apple_eaten = r_eaten;
    assign game_over   = r_game_over;
    assign busy        = r_busy;

endmodule

// File: tb/tb_snake_mover.sv
// Directed bench for snake_mover: moves, reversal rejection, growth, walls, self collision, length cap.
module tb_snake_mover;

    localparam int MAX_LEN = 33;

    logic                  clk_pix = 1'b0;
    logic                  rst_n;
    logic                  step;
    logic [1:0]            dir;
    logic                  restart;
    logic [9:0]            apple_x;
    logic [8:0]            apple_y;
    logic [9:0]            head_x;
    logic [8:0]            head_y;
    logic [7:0]            snake_len;
    logic [MAX_LEN*10-1:0] body_bus_x;
    logic [MAX_LEN*9-1:0]  body_bus_y;
    logic                  apple_eaten;
    logic                  game_over;
    logic                  busy;

    int n_checks = 0;
    int n_errors = 0;
    int bc, en, ea, ga;

    snake_mover dut (
        .clk_pix(clk_pix), .rst_n(rst_n), .step(step), .dir(dir), .restart(restart),
        .apple_x(apple_x), .apple_y(apple_y), .head_x(head_x), .head_y(head_y),
        .snake_len(snake_len), .body_bus_x(body_bus_x), .body_bus_y(body_bus_y),
        .apple_eaten(apple_eaten), .game_over(game_over), .busy(busy)
    );

    always #5 clk_pix = ~clk_pix;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_seg(input string tag, input int i, input int x, input int y);
        check({tag, "_x"}, 32'(body_bus_x[i*10 +: 10]), 32'(x));
        check({tag, "_y"}, 32'(body_bus_y[i*9 +: 9]), 32'(y));
    endtask

    task automatic do_restart();
        @(negedge clk_pix);
        restart = 1'b1;
        @(negedge clk_pix);
        restart = 1'b0;
    endtask

    // Issue one step and watch it until busy drops; sample index 1 is cycle T+1.
    task automatic do_step(input logic [1:0] d);
        bit done;
        @(negedge clk_pix);
        dir  = d;
        step = 1'b1;
        @(negedge clk_pix);
        step = 1'b0;
        bc = 0; en = 0; ea = 0; ga = 0; done = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            if (busy) bc++;
            if (apple_eaten) begin en++; ea = c; end
            if (game_over && ga == 0) ga = c;
            if (!busy) begin done = 1'b1; break; end
            @(negedge clk_pix);
        end
        if (!done) check("busy_timeout", 32'(done), 32'd1);
    endtask

    task automatic check_reset_state(input string tag);
        check_seg({tag, "_s0"}, 0, 320, 240);
        check_seg({tag, "_s1"}, 1, 304, 240);
        check_seg({tag, "_s2"}, 2, 288, 240);
        check({tag, "_len"}, 32'(snake_len), 32'd3);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_go"}, 32'(game_over), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; step = 1'b0; dir = 2'd1; restart = 1'b0;
        apple_x = 10'd0; apple_y = 9'd0;
        #23;
        check_reset_state("rst");
        check("rst_head_x", 32'(head_x), 32'd320);
        check("rst_head_y", 32'(head_y), 32'd240);
        check("rst_eaten", 32'(apple_eaten), 32'd0);
        for (int i = 3; i < MAX_LEN; i++) check_seg("rst_tailslot", i, 288, 240);
        rst_n = 1'b1;

        // single step right
        do_step(2'd1);
        check("r1_head_x", 32'(head_x), 32'd336);
        check_seg("r1_s1", 1, 320, 240);
        check_seg("r1_s2", 2, 304, 240);
        check("r1_len", 32'(snake_len), 32'd3);
        check("r1_busy_cycles", 32'(bc), 32'd3);
        check("r1_no_eat", 32'(en), 32'd0);

        // reversal request is ignored, then turn up
        do_restart();
        check_reset_state("rs1");
        do_step(2'd3);
        check("rev_head_x", 32'(head_x), 32'd336);
        check("rev_head_y", 32'(head_y), 32'd240);
        do_step(2'd0);
        check("up_head_x", 32'(head_x), 32'd336);
        check("up_head_y", 32'(head_y), 32'd224);

        // eat one apple
        do_restart();
        apple_x = 10'd336; apple_y = 9'd240;
        do_step(2'd1);
        apple_x = 10'd0; apple_y = 9'd0;
        check("eat_count", 32'(en), 32'd1);
        check("eat_at_t2", 32'(ea), 32'd2);
        check("eat_len", 32'(snake_len), 32'd4);
        check_seg("eat_s3", 3, 288, 240);
        check("eat_busy_cycles", 32'(bc), 32'd4);

        // right wall
        do_restart();
        for (int k = 0; k < 19; k++) do_step(2'd1);
        check("rw_head_x", 32'(head_x), 32'd624);
        check("rw_alive", 32'(game_over), 32'd0);
        do_step(2'd1);
        check("rw_stay_x", 32'(head_x), 32'd624);
        check("rw_go_at_t2", 32'(ga), 32'd2);
        check("rw_busy_cycles", 32'(bc), 32'd1);
        do_step(2'd0);
        check("rw_ignored_y", 32'(head_y), 32'd240);
        check("rw_dead_busy", 32'(bc), 32'd0);
        check("rw_sticky", 32'(game_over), 32'd1);
        do_restart();
        check_reset_state("rs2");

        // left wall from x cell 0
        do_step(2'd0);
        for (int k = 0; k < 20; k++) do_step(2'd3);
        check("lw_head_x", 32'(head_x), 32'd0);
        check("lw_alive", 32'(game_over), 32'd0);
        do_step(2'd3);
        check("lw_stay_x", 32'(head_x), 32'd0);
        check("lw_go", 32'(game_over), 32'd1);
        check("lw_go_at_t2", 32'(ga), 32'd2);

        // grow to 5 then turn into own body
        do_restart();
        apple_x = 10'd336; apple_y = 9'd240;
        do_step(2'd1);
        apple_x = 10'd352;
        do_step(2'd1);
        apple_x = 10'd0; apple_y = 9'd0;
        check("sc_len", 32'(snake_len), 32'd5);
        do_step(2'd0);
        do_step(2'd3);
        check("sc_alive", 32'(game_over), 32'd0);
        check_seg("sc_pre_s3", 3, 336, 240);
        do_step(2'd2);
        check("sc_busy_cycles", 32'(bc), 32'd5);
        check("sc_go_at", 32'(ga), 32'd6);
        check("sc_go", 32'(game_over), 32'd1);
        check_seg("sc_head", 0, 336, 240);

        // fill to MAX_LEN then eat once more
        do_restart();
        for (int k = 0; k < 19; k++) begin
            apple_x = 10'((21 + k) * 16); apple_y = 9'd240;
            do_step(2'd1);
        end
        check("max_len22", 32'(snake_len), 32'd22);
        for (int k = 0; k < 11; k++) begin
            apple_x = 10'd624; apple_y = 9'((14 - k) * 16);
            do_step(2'd0);
        end
        check("max_len33", 32'(snake_len), 32'd33);
        apple_x = 10'd624; apple_y = 9'd48;
        do_step(2'd0);
        check("max_sat_len", 32'(snake_len), 32'd33);
        check("max_sat_eat", 32'(en), 32'd1);
        check("max_head_y", 32'(head_y), 32'd48);
        check("max_busy_cycles", 32'(bc), 32'd33);
        check("max_alive", 32'(game_over), 32'd0);
        apple_x = 10'd0; apple_y = 9'd0;

        // asynchronous reset mid-CHECK
        @(negedge clk_pix);
        dir = 2'd0; step = 1'b1;
        @(negedge clk_pix);
        step = 1'b0;
        @(negedge clk_pix);
        #2 rst_n = 1'b0;
        #1;
        check_reset_state("arst");
        @(negedge clk_pix);
        rst_n = 1'b1;
        do_step(2'd1);
        check("arst_step_x", 32'(head_x), 32'd336);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
